adder_initiator: RTL

Requester end of the sample/done adder handshake. It accepts operand pairs from an upstream valid/ready port and buffers them in a small FIFO. It issues each pair to the 8-bit adder as a one-cycle `sample` pulse, waits for the adder's `done`, captures `c`, and returns one response per request. It sits between a test/stimulus source and the adder, and optionally self-checks the returned sum.

---
 rtl/adder_initiator_pkg.sv | 27 ++
 rtl/adder_initiator_if.sv | 36 +++
 rtl/adder_initiator_fifo.sv | 52 +++++
 rtl/adder_initiator.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/adder_initiator_pkg.sv
// Shared types for the adder initiator: FSM states, widths, FIFO entry.
// Helper sum function feeds the optional self-check path.
package adder_initiator_pkg;

   localparam int OP_W  = 8;
   localparam int SUM_W = 9;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } init_state_e;

   typedef struct packed {
      logic [OP_W-1:0] a;
      logic [OP_W-1:0] b;
   } req_entry_t;

   function automatic logic [SUM_W-1:0] op_sum(
      input logic [OP_W-1:0] x,
      input logic [OP_W-1:0] y
   );
      return {1'b0, x} + {1'b0, y};
   endfunction

endpackage

// File: rtl/adder_initiator_if.sv
// Request, adder and response signals of the adder initiator.
// master = initiator side, slave = stimulus/adder/consumer side.
interface adder_initiator_if;
   import adder_initiator_pkg::*;

   logic             req_valid;
   logic [OP_W-1:0]  req_a;
   logic [OP_W-1:0]  req_b;
   logic             req_ready;
   logic             sample;
   logic [OP_W-1:0]  a;
   logic [OP_W-1:0]  b;
   logic             done;
   logic [SUM_W-1:0] c;
   logic             resp_valid;
   logic [SUM_W-1:0] resp_sum;
   logic             resp_err;
   logic             resp_timeout;
   logic [15:0]      txn_cnt;
   logic [15:0]      err_cnt;

   modport master (
      input  req_valid, req_a, req_b, done, c,
      output req_ready, sample, a, b,
      output resp_valid, resp_sum, resp_err,
      output resp_timeout, txn_cnt, err_cnt
   );

   modport slave (
      output req_valid, req_a, req_b, done, c,
      input  req_ready, sample, a, b,
      input  resp_valid, resp_sum, resp_err,
      input  resp_timeout, txn_cnt, err_cnt
   );

endinterface

// File: rtl/adder_initiator_fifo.sv
// Synchronous request FIFO; pointers carry one extra wrap bit
// so full and empty are distinguished without a counter.
module adder_initiator_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push_i,
   input  logic [W-1:0] wdata_i,
   input  logic         pop_i,
   output logic [W-1:0] rdata_o,
   output logic         full_o,
   output logic         empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem_q [DEPTH];
   logic [AW:0]  wp_q;
   logic [AW:0]  rp_q;
   logic         do_push;
   logic         do_pop;

   assign empty_o = (wp_q == rp_q);
   assign full_o  = (wp_q[AW] != rp_q[AW]) &&
                    (wp_q[AW-1:0] == rp_q[AW-1:0]);
   assign rdata_o = mem_q[rp_q[AW-1:0]];
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wp_q[AW-1:0]] <= wdata_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp_q <= '0;
         rp_q <= '0;
      end else begin
         if (do_push) begin
            wp_q <= wp_q + (AW+1)'(1);
         end
         if (do_pop) begin
            rp_q <= rp_q + (AW+1)'(1);
         end
      end
   end

endmodule

// File: rtl/adder_initiator.sv
// Requester side of the sample/done adder handshake, one txn in flight.
// Define ADDER_INITIATOR_CHECK_EN to compare each returned sum to a+b.
module adder_initiator
   import adder_initiator_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 8
) (
   input logic               clk,
   input logic               rst_n,
   adder_initiator_if.master bus
);

   localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

   req_entry_t       push_ent;
   req_entry_t       pop_ent;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;

   init_state_e      state_q;
   logic             sample_q;
   logic [OP_W-1:0]  a_q;
   logic [OP_W-1:0]  b_q;
   logic             done_q;
   logic [7:0]       tmo_q;
   logic [7:0]       tmo_d;
   logic             rv_q;
   logic [SUM_W-1:0] sum_q;
   logic             err_q;
   logic             to_q;
   logic [15:0]      txn_q;
   logic [15:0]      errc_q;

   logic             done_rise;
   logic             fin;
   logic             fin_err;
   logic             mis;

   assign push_ent      = {bus.req_a, bus.req_b};
   assign push          = bus.req_valid && !full;
   assign pop           = (state_q == IDLE) && !empty;
   assign bus.req_ready = !full;

   adder_initiator_fifo #(
      .DEPTH (DEPTH),
      .W     ($bits(req_entry_t))
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .wdata_i (push_ent),
      .pop_i   (pop),
      .rdata_o (pop_ent),
      .full_o  (full),
      .empty_o (empty)
   );

`ifdef ADDER_INITIATOR_CHECK_EN
   logic [SUM_W-1:0] exp_q;
   assign mis = (bus.c != exp_q);
`else
   assign mis = 1'b0;
`endif

   // Only a fresh done edge counts; a level left over is ignored.
   assign done_rise = bus.done && !done_q;
   assign tmo_d     = tmo_q + 8'd1;
   assign fin       = (state_q == WAIT) &&
                      (done_rise || (tmo_d == TO_LIM));
   assign fin_err   = done_rise ? mis : 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         sample_q <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         done_q   <= 1'b0;
         tmo_q    <= '0;
         rv_q     <= 1'b0;
         sum_q    <= '0;
         err_q    <= 1'b0;
         to_q     <= 1'b0;
         txn_q    <= '0;
         errc_q   <= '0;
`ifdef ADDER_INITIATOR_CHECK_EN
         exp_q    <= '0;
`endif
      end else begin
         done_q   <= bus.done;
         sample_q <= 1'b0;
         rv_q     <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (!empty) begin
                  a_q      <= pop_ent.a;
                  b_q      <= pop_ent.b;
                  sample_q <= 1'b1;
                  state_q  <= ISSUE;
`ifdef ADDER_INITIATOR_CHECK_EN
                  exp_q    <= op_sum(pop_ent.a, pop_ent.b);
`endif
               end
            end
            ISSUE: begin
               tmo_q   <= '0;
               state_q <= WAIT;
            end
            WAIT: begin
               tmo_q <= tmo_d;
               if (fin) begin
                  sum_q   <= done_rise ? bus.c : '0;
                  to_q    <= !done_rise;
                  err_q   <= fin_err;
                  rv_q    <= 1'b1;
                  txn_q   <= txn_q + 16'd1;
                  state_q <= RESP;
                  if (fin_err && (errc_q != 16'hFFFF)) begin
                     errc_q <= errc_q + 16'd1;
                  end
               end
            end
            RESP: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.sample       = sample_q;
   assign bus.a            = a_q;
   assign bus.b            = b_q;
   assign bus.resp_valid   = rv_q;
   assign bus.resp_sum     = sum_q;
   assign bus.resp_err     = err_q;
   assign bus.resp_timeout = to_q;
   assign bus.txn_cnt      = txn_q;
   assign bus.err_cnt      = errc_q;

endmodule
